// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_pkg                                                        |
// | Core-wide constants shared by fetch, decode and hazard logic.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package riscv_pkg;
   localparam int          XLEN       = 32;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          IMEM_DEPTH = 256;
endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_reg                                                        |
// | IF/ID pipeline register with hold and bubble-insert controls.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold,
   input  logic            flush,
   input  logic [XLEN-1:0] d_inst,
   input  logic [XLEN-1:0] d_pc,
   input  logic [XLEN-1:0] d_pc4,
   output logic            q_valid,
   output logic [XLEN-1:0] q_inst,
   output logic [XLEN-1:0] q_pc,
   output logic [XLEN-1:0] q_pc4
);

   logic            r_valid;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc4;

   // A bubble keeps the old pc/pc4 so only valid/inst toggle on a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_inst  <= NOP_INST;
         r_pc    <= '0;
         r_pc4   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_inst  <= NOP_INST;
      end else if (!hold) begin
         r_valid <= 1'b1;
         r_inst  <= d_inst;
         r_pc    <= d_pc;
         r_pc4   <= d_pc4;
      end
   end

   assign q_valid = r_valid;
   assign q_inst  = r_inst;
   assign q_pc    = r_pc;
   assign q_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage                                                      |
// | PC register, next-PC selection, range/fault check, fetch count.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
   parameter int          IMEM_DEPTH = riscv_pkg::IMEM_DEPTH,
   parameter logic [31:0] NOP_INST   = riscv_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] imem_inst,
   output logic [31:0] imem_addr,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] c_depth = 32'(IMEM_DEPTH);

   logic [XLEN-1:0] r_pc;
   logic            r_fault;
   logic [31:0]     r_count;
   logic            w_in_range;
   logic [XLEN-1:0] w_pc4;
   logic            w_flush;

   assign w_pc4      = r_pc + 32'd4;
   assign w_in_range = ({2'b00, r_pc[31:2]} < c_depth) && (r_pc[1:0] == 2'b00);
   // An out-of-range PC parks here and emits bubbles until redirected.
   assign w_flush    = redirect_valid || (!stall && !w_in_range);
   assign imem_addr  = {2'b00, r_pc[31:2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_pc <= {redirect_target[31:2], 2'b00};
         if (redirect_target[1:0] != 2'b00) r_fault <= 1'b1;
      end else if (!stall) begin
         if (w_in_range) begin
            r_pc    <= w_pc4;
            r_count <= r_count + 32'd1;
         end else begin
            r_fault <= 1'b1;
         end
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .hold    (stall),
      .flush   (w_flush),
      .d_inst  (imem_inst),
      .d_pc    (r_pc),
      .d_pc4   (w_pc4),
      .q_valid (if_id_valid),
      .q_inst  (if_id_inst),
      .q_pc    (if_id_pc),
      .q_pc4   (if_id_pc4)
   );

   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

endmodule
`default_nettype wire
